// File: rtl/bus_arbiter_rr.sv
// Two-master round-robin bus arbiter with registered, state-decoded grants.
// Optional hold-timeout under contention is enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter_rr #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic m0_req,
  input  logic m1_req,
  output logic m0_grant,
  output logic m1_grant,
  output logic m_sel,
  output logic arb_busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_e state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   contended;
  logic   hold_expired;

  assign contended = m0_req & m1_req;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt_q, hold_cnt_d;

  assign hold_expired = contended && (hold_cnt_q == HOLD_LAST);

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_d != state_q) begin
      hold_cnt_d = '0;
    end else if ((state_q == GRANT0 || state_q == GRANT1) && contended) begin
      hold_cnt_d = hold_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  logic unused_hold_cfg;

  assign hold_expired    = 1'b0;
  assign unused_hold_cfg = ^HOLD_LAST;
`endif

  // State register; last_grant resets to 1 so master 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (contended) begin
          state_d = last_grant_q ? GRANT0 : GRANT1;
        end else if (m0_req) begin
          state_d = GRANT0;
        end else if (m1_req) begin
          state_d = GRANT1;
        end
      end
      GRANT0: begin
        if (!m0_req) begin
          state_d = m1_req ? GRANT1 : IDLE;
        end else if (hold_expired) begin
          state_d = GRANT1;
        end
      end
      GRANT1: begin
        if (!m1_req) begin
          state_d = m0_req ? GRANT0 : IDLE;
        end else if (hold_expired) begin
          state_d = GRANT0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_d == GRANT0) begin
      last_grant_d = 1'b0;
    end else if (state_d == GRANT1) begin
      last_grant_d = 1'b1;
    end
  end

  always_comb begin
    m0_grant = 1'b0;
    m1_grant = 1'b0;
    m_sel    = 1'b0;
    arb_busy = 1'b0;
    case (state_q)
      GRANT0: begin
        m0_grant = 1'b1;
        arb_busy = 1'b1;
      end
      GRANT1: begin
        m1_grant = 1'b1;
        m_sel    = 1'b1;
        arb_busy = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Randomized and directed bench for bus_arbiter_rr against an owner/last-winner model.
module tb_bus_arbiter_rr;

  localparam int MAXH = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic m0_req = 1'b0;
  logic m1_req = 1'b0;
  logic m0_grant, m1_grant, m_sel, arb_busy;

  int total = 0;
  int bad = 0;

  // Model: owner -1 = nobody, 0 / 1 = master index.
  int owner = -1;
  int last = 1;
  int held = 0;

`ifdef ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  bus_arbiter_rr #(.MAX_HOLD(MAXH)) dut (
    .clk(clk), .reset_n(reset_n), .m0_req(m0_req), .m1_req(m1_req),
    .m0_grant(m0_grant), .m1_grant(m1_grant), .m_sel(m_sel), .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] expected_outs(input int who);
    if (who == 0) return 4'b1001;
    if (who == 1) return 4'b0111;
    return 4'b0000;
  endfunction

  task automatic model_reset();
    owner = -1;
    last = 1;
    held = 0;
  endtask

  task automatic model_edge();
    bit r[2];
    int nxt;
    r[0] = m0_req;
    r[1] = m1_req;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (owner < 0) begin
      if (r[0] && r[1]) nxt = 1 - last;
      else if (r[0]) nxt = 0;
      else if (r[1]) nxt = 1;
      else nxt = -1;
    end else begin
      if (r[owner] && r[1-owner] && TMO && held == MAXH - 1) nxt = 1 - owner;
      else if (r[owner]) nxt = owner;
      else if (r[1-owner]) nxt = 1 - owner;
      else nxt = -1;
    end
    if (nxt != owner) held = 0;
    else if (owner >= 0 && r[0] && r[1]) held++;
    owner = nxt;
    if (nxt >= 0) last = nxt;
  endtask

  task automatic check_outs(input string name);
    logic [3:0] got, exp;
    got = {m0_grant, m1_grant, m_sel, arb_busy};
    exp = expected_outs(owner);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got{g0,g1,sel,busy}=%b want=%b", name, $time, got, exp);
    end
  endtask

  task automatic step(input string name);
    @(posedge clk);
    model_edge();
    #1;
    check_outs(name);
  endtask

  task automatic go_idle();
    m0_req = 1'b0;
    m1_req = 1'b0;
    step("idle");
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    m0_req = 1'b1;
    m1_req = 1'b1;
    model_reset();
    #1;
    check_outs("reset_outs");
    step("reset_held");
    #3 reset_n = 1'b1;
    step("first_tie");
    total++;
    if (m0_grant !== 1'b1 || m_sel !== 1'b0) begin
      bad++;
      $display("FAIL first_tie_m0 got g0=%b sel=%b want g0=1 sel=0", m0_grant, m_sel);
    end
  endtask

  task automatic test_single();
    int cnt = 0;
    go_idle();
    m1_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step("single_m1");
      if (m1_grant === 1'b1 && m_sel === 1'b1) cnt++;
    end
    m1_req = 1'b0;
    step("single_release");
    total++;
    if (cnt != 10 || m1_grant !== 1'b0) begin
      bad++;
      $display("FAIL single_len got cycles=%0d g1=%b want cycles=10 g1=0", cnt, m1_grant);
    end
  endtask

  task automatic test_tie();
    int order[3];
    for (int r = 0; r < 3; r++) begin
      go_idle();
      m0_req = 1'b1;
      m1_req = 1'b1;
      step("tie_grant");
      order[r] = m1_grant ? 1 : 0;
      for (int c = 0; c < 4; c++) step("tie_hold");
      m0_req = 1'b0;
      m1_req = 1'b0;
      step("tie_release");
    end
    if (!TMO) begin
      total++;
      if (order[0] != 0 || order[1] != 1 || order[2] != 0) begin
        bad++;
        $display("FAIL tie_order got %0d,%0d,%0d want 0,1,0", order[0], order[1], order[2]);
      end
    end
  endtask

  task automatic test_back_to_back();
    go_idle();
    m0_req = 1'b1;
    step("b2b_m0");
    m1_req = 1'b1;
    step("b2b_contend");
    m0_req = 1'b0;
    step("b2b_handover");
    total++;
    if (m0_grant !== 1'b0 || m1_grant !== 1'b1 || arb_busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_same_edge got g0=%b g1=%b busy=%b want 0 1 1", m0_grant, m1_grant, arb_busy);
    end
    m1_req = 1'b0;
    step("b2b_done");
  endtask

  task automatic test_timeout();
    int runs[$];
    int run = 0;
    logic prev = 1'b0;
    go_idle();
    m0_req = 1'b1;
    m1_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step("timeout_contend");
      if (i > 0 && m1_grant !== prev) begin
        runs.push_back(run);
        run = 0;
      end
      prev = m1_grant;
      run++;
    end
    runs.push_back(run);
    total++;
    if (TMO) begin
      if (runs.size() != 4 || runs[0] != 4 || runs[1] != 4 || runs[2] != 4) begin
        bad++;
        $display("FAIL timeout_blocks got %0d blocks first=%0d want 4 blocks of 4", runs.size(), runs[0]);
      end
    end else begin
      if (runs.size() != 1 || m0_grant !== 1'b1) begin
        bad++;
        $display("FAIL no_timeout_hold got blocks=%0d g0=%b want 1 block g0=1", runs.size(), m0_grant);
      end
    end
    go_idle();
  endtask

  task automatic test_async_reset();
    m1_req = 1'b1;
    step("async_g1");
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({m0_grant, m1_grant, m_sel, arb_busy} !== 4'b0000) begin
      bad++;
      $display("FAIL async_drop got %b want 0000", {m0_grant, m1_grant, m_sel, arb_busy});
    end
    m0_req = 1'b1;
    step("async_held");
    #3 reset_n = 1'b1;
    step("async_tie");
    total++;
    if (m0_grant !== 1'b1) begin
      bad++;
      $display("FAIL async_tie_m0 got g0=%b want 1", m0_grant);
    end
  endtask

  task automatic test_random();
    go_idle();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0) m0_req = ~m0_req;
      if ($urandom_range(3) == 0) m1_req = ~m1_req;
      step("random");
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
